// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer and its arbiter.
// Holds the state encoding, the ALU opcodes and the enable-bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    CAPT   = 3'd4,
    RESP   = 3'd5
  } seq_state_t;

  localparam logic [3:0] OP_ZERO = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;

  localparam int unsigned ALU_EN_A = 0;
  localparam int unsigned ALU_EN_B = 1;
  localparam int unsigned ALU_EN_R = 2;

  // Index of the requester selected by a one-hot two-way grant.
  function automatic logic grant_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the requests;
// the priority pointer only moves when the parent accepts the grant.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // On contention the requester that did not win last time goes first.
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one ALU between two requesters: arbitrates, steps the ALU through
// load A, load B and execute, then returns the result over a valid/ready port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_async_reset_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*OP_W-1:0]   i_req_op,
  input  logic [2*DATA_W-1:0] i_req_a,
  input  logic [2*DATA_W-1:0] i_req_b,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_id,
  output logic                o_busy,
  output logic [DATA_W-1:0]   o_alu_bus,
  output logic [2:0]          o_alu_enable,
  output logic [OP_W-1:0]     o_alu_func_sel,
  input  logic [DATA_W-1:0]   i_alu_result
);

  seq_state_t          r_state;
  logic                r_armed;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_valid;

  logic [1:0]          w_grant;
  logic                w_accept;
  logic                w_sel;

  rr_arbiter2 u_arbiter (
    .i_clk   (i_clk),
    .i_rst_n (i_async_reset_n),
    .i_req   (i_req_valid),
    .i_accept(w_accept),
    .o_grant (w_grant)
  );

  // r_armed keeps req_ready low while reset is held, even if requests are up.
  assign o_req_ready = (r_state == IDLE && r_armed) ? w_grant : 2'b00;
  assign w_accept    = |o_req_ready;
  assign w_sel       = grant_idx(w_grant);

  always_ff @(posedge i_clk or negedge i_async_reset_n) begin
    if (!i_async_reset_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_sel ? i_req_op[2*OP_W-1:OP_W]     : i_req_op[OP_W-1:0];
            r_a     <= w_sel ? i_req_a[2*DATA_W-1:DATA_W]  : i_req_a[DATA_W-1:0];
            r_b     <= w_sel ? i_req_b[2*DATA_W-1:DATA_W]  : i_req_b[DATA_W-1:0];
            r_id    <= w_sel;
            r_state <= LOAD_A;
          end
        end
        LOAD_A: r_state <= LOAD_B;
        LOAD_B: r_state <= EXEC;
        EXEC:   r_state <= CAPT;
        CAPT: begin
          // The ALU latched its result at the end of EXEC.
          r_rsp_data  <= i_alu_result;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_alu_bus      = '0;
    o_alu_enable   = 3'b000;
    o_alu_func_sel = OP_W'(OP_ZERO);
    unique case (r_state)
      LOAD_A: begin
        o_alu_bus              = r_a;
        o_alu_enable[ALU_EN_A] = 1'b1;
      end
      LOAD_B: begin
        o_alu_bus              = r_b;
        o_alu_enable[ALU_EN_B] = 1'b1;
      end
      EXEC: begin
        o_alu_func_sel         = r_op;
        o_alu_enable[ALU_EN_R] = 1'b1;
      end
      default: begin
        o_alu_bus = '0;
      end
    endcase
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_id;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered ALU model attached
// to the operand bus, enables and function select.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_id;
  logic        busy;
  logic [7:0]  alu_bus;
  logic [2:0]  alu_enable;
  logic [3:0]  alu_func_sel;
  logic [7:0]  alu_result;

  logic [7:0]  m_a;
  logic [7:0]  m_b;

  int n_checks = 0;
  int n_errors = 0;

  alu_sequencer #(
    .DATA_W(8),
    .OP_W  (4)
  ) dut (
    .i_clk          (clk),
    .i_async_reset_n(rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_op       (req_op),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_data     (rsp_data),
    .o_rsp_id       (rsp_id),
    .o_busy         (busy),
    .o_alu_bus      (alu_bus),
    .o_alu_enable   (alu_enable),
    .o_alu_func_sel (alu_func_sel),
    .i_alu_result   (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: operands and result are registers loaded by the enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a        <= 8'h00;
      m_b        <= 8'h00;
      alu_result <= 8'h00;
    end else begin
      if (alu_enable[0]) m_a <= alu_bus;
      if (alu_enable[1]) m_b <= alu_bus;
      if (alu_enable[2]) begin
        case (alu_func_sel)
          4'h1:    alu_result <= m_a + m_b;
          4'h2:    alu_result <= m_a - m_b;
          4'h3:    alu_result <= m_a ^ m_b;
          default: alu_result <= 8'h00;
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from requester id and follow it to the response.
  task automatic run_op(input int id, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int stall,
                        input string tag);
    int n;
    int lat;
    req_op[4*id +: 4] = op;
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_valid[id]     = 1'b1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(2'b01 << id));
    lat = 0;
    tick();
    lat++;
    req_valid[id] = 1'b0;
    check_eq({tag, "_en_a"}, 32'(alu_enable), 32'(3'b001));
    check_eq({tag, "_bus_a"}, 32'(alu_bus), 32'(a));
    tick();
    lat++;
    check_eq({tag, "_en_b"}, 32'(alu_enable), 32'(3'b010));
    check_eq({tag, "_bus_b"}, 32'(alu_bus), 32'(b));
    tick();
    lat++;
    check_eq({tag, "_en_r"}, 32'(alu_enable), 32'(3'b100));
    check_eq({tag, "_func"}, 32'(alu_func_sel), 32'(op));
    while (!rsp_valid && lat < 12) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
    if (stall > 0) begin
      rsp_ready          = 1'b0;
      req_valid[1 - id]  = 1'b1;
      for (int s = 0; s < stall; s++) begin
        tick();
        check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
        check_eq({tag, "_hold_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_hold_busy"}, 32'(busy), 32'd1);
      end
      rsp_ready         = 1'b1;
      req_valid[1 - id] = 1'b0;
    end
    tick();
    check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_alu_out", 32'({alu_bus, alu_enable, alu_func_sel}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op(0, 4'h1, 8'h05, 8'h03, 8'h08, 0, "add");
    run_op(1, 4'h2, 8'h02, 8'h05, 8'hFD, 0, "sub_wrap");
    run_op(0, 4'h3, 8'hAA, 8'h0F, 8'hA5, 0, "xor");
    run_op(1, 4'h1, 8'h40, 8'h02, 8'h42, 3, "stall");
    run_op(0, 4'h0, 8'hFF, 8'h01, 8'h00, 0, "op_zero");
    run_op(1, 4'h7, 8'hFF, 8'h01, 8'h00, 0, "op_7");
    run_op(0, 4'h9, 8'hFF, 8'h01, 8'h00, 0, "op_9");
    run_op(1, 4'h1, 8'hFF, 8'h01, 8'h00, 0, "add_wrap");

    // Both requesters valid straight out of reset: grants alternate from 0.
    rst_n     = 1'b0;
    req_op    = {4'h3, 4'h1};
    req_a     = {8'hF0, 8'h01};
    req_b     = {8'h0F, 8'h02};
    req_valid = 2'b11;
    #1;
    check_eq("rr_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      check_eq($sformatf("rr_grant%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      n = 0;
      while (!rsp_valid && n < 12) begin
        tick();
        n++;
      end
      check_eq($sformatf("rr_data%0d", k), 32'(rsp_data), (k % 2 == 0) ? 32'h03 : 32'hFF);
      check_eq($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(k % 2));
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Reset during LOAD_B aborts the operation with no response.
    req_op[3:0]   = 4'h1;
    req_a[7:0]    = 8'h11;
    req_b[7:0]    = 8'h22;
    req_valid[0]  = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid[0] = 1'b0;
    tick();
    check_eq("abort_in_load_b", 32'(alu_enable), 32'(3'b010));
    rst_n = 1'b0;
    #1;
    check_eq("abort_alu_out", 32'({alu_bus, alu_enable, alu_func_sel}), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
    check_eq("abort_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check_eq("abort_no_rsp", 32'(seen), 32'd0);
    run_op(0, 4'h1, 8'h10, 8'h20, 8'h30, 0, "post_abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
